// File: rtl/iir_1st_mc.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | iir_1st_mc : time-multiplexed first-order IIR, NCH channels, shared MAC   |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
module iir_1st_mc #(
  parameter int DW  = 16,
  parameter int CW  = 16,
  parameter int CF  = 14,
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 coef_we,
  input  logic [CHW-1:0]       coef_ch,
  input  logic                 coef_sel,
  input  logic signed [CW-1:0] coef_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CHW-1:0]       in_ch,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CHW-1:0]       out_ch,
  output logic signed [DW-1:0] out_data,
  output logic                 out_sat
);

  localparam int AW    = DW + CW + 1;
  localparam int PW    = DW + CW;
  localparam int NSLOT = 1 << CHW;

  localparam logic signed [CW-1:0] B_UNITY  = CW'(1 << CF);
  localparam logic signed [AW-1:0] RND_HALF = {{(AW-CF){1'b0}}, 1'b1, {(CF-1){1'b0}}};
  localparam logic signed [AW-1:0] SAT_MAX  = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN  = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // Channel indices at or above NCH are silently ignored everywhere.
  logic [NSLOT-1:0] ch_ok;
  for (genvar i = 0; i < NSLOT; i++) begin : g_ch_ok
    assign ch_ok[i] = (i < NCH);
  end

  logic                 s1_valid_q, s1_valid_d;
  logic [CHW-1:0]       s1_ch_q, s1_ch_d;
  logic signed [DW-1:0] s1_data_q, s1_data_d;

  logic signed [DW-1:0] y_q [NSLOT];
  logic signed [DW-1:0] y_d [NSLOT];
  logic signed [CW-1:0] b_q [NSLOT];
  logic signed [CW-1:0] b_d [NSLOT];
  logic signed [CW-1:0] a_q [NSLOT];
  logic signed [CW-1:0] a_d [NSLOT];

  logic                 out_valid_q, out_valid_d;
  logic [CHW-1:0]       out_ch_q, out_ch_d;
  logic signed [DW-1:0] out_data_q, out_data_d;
  logic                 out_sat_q, out_sat_d;

  logic                 stall;
  logic                 advance;
  logic                 accept;

  logic signed [CW-1:0] coef_b;
  logic signed [CW-1:0] coef_a;
  logic signed [DW-1:0] y_prev;
  logic signed [PW-1:0] prod_b;
  logic signed [PW-1:0] prod_a;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] rnd;
  logic signed [AW-1:0] shr;
  logic signed [DW-1:0] y_new;
  logic                 y_sat;

  assign stall    = out_valid_q & ~out_ready;
  assign advance  = ~stall;
  assign accept   = in_valid & advance;
  assign in_ready = advance;

  always_comb begin
    coef_b = b_q[s1_ch_q];
    coef_a = a_q[s1_ch_q];
    y_prev = y_q[s1_ch_q];
    prod_b = PW'(s1_data_q) * PW'(coef_b);
    prod_a = PW'(y_prev) * PW'(coef_a);
    acc    = AW'(prod_b) + AW'(prod_a);
    rnd    = acc + RND_HALF;
    shr    = rnd >>> CF;
    y_sat  = 1'b0;
    y_new  = shr[DW-1:0];
    if (shr > SAT_MAX) begin
      y_new = SAT_MAX[DW-1:0];
      y_sat = 1'b1;
    end else if (shr < SAT_MIN) begin
      y_new = SAT_MIN[DW-1:0];
      y_sat = 1'b1;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_ch_d     = s1_ch_q;
    s1_data_d   = s1_data_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    y_d         = y_q;
    b_d         = b_q;
    a_d         = a_q;

    if (clr) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      for (int i = 0; i < NSLOT; i++) y_d[i] = '0;
    end else if (advance) begin
      s1_valid_d  = accept & ch_ok[in_ch];
      if (accept) begin
        s1_ch_d   = in_ch;
        s1_data_d = in_data;
      end
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_ch_d         = s1_ch_q;
        out_data_d       = y_new;
        out_sat_d        = y_sat;
        y_d[s1_ch_q]     = y_new;
      end
    end

    // Coefficient writes bypass stall and clear; the datapath above sees the old value.
    if (coef_we && ch_ok[coef_ch]) begin
      if (coef_sel) a_d[coef_ch] = coef_data;
      else          b_d[coef_ch] = coef_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_ch_q     <= '0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        y_q[i] <= '0;
        b_q[i] <= B_UNITY;
        a_q[i] <= '0;
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_ch_q     <= s1_ch_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      y_q         <= y_d;
      b_q         <= b_d;
      a_q         <= a_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule
`default_nettype wire
